// File: rtl/shift_add_mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encodings,
// default operand width and the count register width helper.
package shift_add_mul_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must reach width-1; never narrower than one bit.
  function automatic int count_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mul_datapath.sv
// Shift-and-add datapath: multiplicand register A and the 2*WIDTH product/
// multiplier register P, advanced one radix-2 step per 'step' pulse.
module mul_datapath
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] p
);

  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p_next;

  // The (WIDTH+1)-bit sum keeps the carry, which becomes the new MSB of P
  // after the right shift, so no product bit is ever lost.
  always_comb begin
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    p_next = {sum, p_q[WIDTH-1:1]};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      p_q <= '0;
    end else if (load) begin
      a_q <= a_in;
      p_q <= {{WIDTH{1'b0}}, b_in};
    end else if (step) begin
      p_q <= p_next;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned multiplier with valid/ready handshakes on both sides.
// Fixed latency of WIDTH busy cycles; control FSM drives mul_datapath.
module shift_add_mul
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic          load, step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (load)      count <= '0;
      else if (step) count <= count + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (count == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a_in (multiplicand),
    .b_in (multiplier),
    .p    (product)
  );

endmodule
